// File: rtl/mac_accumulator.sv
// Accumulation stage of the 16-bit MAC datapath: running sum over a frame, closed on in_last or MAX_TERMS.
// Define MAC_ACC_SAT_EN to saturate the accumulator at all-ones on carry-out instead of wrapping.
module mac_accumulator #(
   parameter int WIDTH     = 16,
   parameter int MAX_TERMS = 16,
   parameter int CNT_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             acc_clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_acc,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   localparam int LO_W = WIDTH / 2;
   localparam int HI_W = WIDTH - LO_W;

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t             r_state;
   logic               r_in_ready;
   logic [WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_acc;
   logic               r_out_ovf;
   logic [CNT_W-1:0]   r_out_count;

   logic [WIDTH:0]     w_sum;
   logic               w_c;
   logic [WIDTH-1:0]   w_acc_next;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_accept;
   logic               w_close;

   // Carry-select add, cin = 0: upper half precomputed for both lower-half carries.
   function automatic logic [WIDTH:0] cs_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [LO_W:0] lo;
      logic [HI_W:0] hi0;
      logic [HI_W:0] hi1;
      lo  = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]};
      hi0 = {1'b0, a[WIDTH-1:LO_W]} + {1'b0, b[WIDTH-1:LO_W]};
      hi1 = hi0 + {{HI_W{1'b0}}, 1'b1};
      return lo[LO_W] ? {hi1, lo[LO_W-1:0]} : {hi0, lo[LO_W-1:0]};
   endfunction

   function automatic logic [WIDTH-1:0] sat_or_wrap(input logic c, input logic [WIDTH-1:0] s);
`ifdef MAC_ACC_SAT_EN
      return c ? {WIDTH{1'b1}} : s;
`else
      return (c == 1'b1) ? s : s;
`endif
   endfunction

   assign w_sum      = cs_add(r_acc, in_product);
   assign w_c        = w_sum[WIDTH];
   assign w_acc_next = sat_or_wrap(w_c, w_sum[WIDTH-1:0]);
   assign w_cnt_inc  = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   assign w_accept   = in_valid & r_in_ready;
   assign w_close    = w_accept & (in_last | (w_cnt_inc == CNT_W'(MAX_TERMS)));

   // Priority: rst > acc_clr > accept/close > out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ACCUM;
         r_in_ready  <= 1'b1;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_acc   <= '0;
         r_out_ovf   <= 1'b0;
         r_out_count <= '0;
      end else if (acc_clr) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         if (r_state == HOLD) begin
            r_state     <= ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_count <= '0;
         end
      end else if (w_close) begin
         r_out_acc   <= w_acc_next;
         r_out_count <= w_cnt_inc;
         r_out_ovf   <= r_ovf | w_c;
         r_out_valid <= 1'b1;
         r_state     <= HOLD;
         r_in_ready  <= 1'b0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
      end else if (w_accept) begin
         r_acc <= w_acc_next;
         r_cnt <= w_cnt_inc;
         r_ovf <= r_ovf | w_c;
      end else if ((r_state == HOLD) && out_ready) begin
         r_out_valid <= 1'b0;
         r_state     <= ACCUM;
         r_in_ready  <= 1'b1;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_acc   = r_out_acc;
   assign out_ovf   = r_out_ovf;
   assign out_count = r_out_count;

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Accumulation stage of the 16-bit MAC datapath. Sits downstream of the multiplier and owns the running-sum register around the 16-bit carry-select adder.
- Accepts one 16-bit product per handshake and adds it to the accumulator using the adder's sum and carry-out, with cin = 0.
- Closes a frame on a last-term flag or on a term-count limit, then presents the result on a valid/ready output port.

Parameters:
- WIDTH, 16, datapath width of product, accumulator and result.
- MAX_TERMS, 16, maximum products per frame; the frame is force-closed when this count is reached. Legal range 1..(2^CNT_W - 1).
- CNT_W, 5, width of the term counter and of out_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- acc_clr  input  1  synchronous frame abort; zeroes the accumulator.
- in_valid  input  1  product available.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  WIDTH  unsigned product from the multiplier.
- in_last  input  1  qualifies in_product as the final term of the frame.
- out_valid  output  1  frame result held on the outputs.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  WIDTH  final accumulated sum.
- out_ovf  output  1  sticky flag: some add in the frame produced carry-out = 1.
- out_count  output  CNT_W  number of terms accumulated in the frame.

Behaviour:
- Reset (rst = 1 at a clock edge) sets:
  - state = ACCUM, acc = 0, cnt = 0, ovf = 0;
  - out_valid = 0, out_acc = 0, out_ovf = 0, out_count = 0;
  - in_ready = 1 from the first cycle after reset is released.
- States: ACCUM and HOLD.
- in_ready = 1 in ACCUM and 0 in HOLD. It is a registered state decode and never depends on out_ready combinationally.
- Accept condition: in_valid & in_ready. On accept:
  - {c, s} = acc + in_product, with cin = 0;
  - acc <= s;
  - cnt <= cnt + 1;
  - ovf <= ovf | c.
- Frame close: an accept with in_last = 1, or an accept that brings cnt + 1 to MAX_TERMS. On close:
  - out_acc <= s, out_count <= cnt + 1, out_ovf <= ovf | c;
  - out_valid <= 1, state <= HOLD;
  - acc, cnt and ovf are zeroed in the same edge.
- Latency: the result is visible 1 cycle after the closing accept.
- HOLD:
  - out_* are stable while out_valid = 1 and out_ready = 0.
  - When out_ready = 1: out_valid <= 0 and state <= ACCUM. in_ready returns to 1 in the following cycle, giving 1 bubble per frame.
- in_valid with in_ready = 0 is ignored. The upstream stage must hold its data.
- Wrap-around: without the optional feature, the sum wraps modulo 2^WIDTH and out_ovf records it. The counter never wraps because of the MAX_TERMS close.
- acc_clr = 1:
  - in ACCUM: acc, cnt and ovf are zeroed and any same-cycle accept is discarded (clr has priority).
  - in HOLD: out_valid <= 0 and state <= ACCUM; out_acc, out_count and out_ovf are zeroed.
- Priority: rst > acc_clr > accept/close > out_ready.
- rst or acc_clr mid-frame discards partial terms with no output. in_ready = 1 on the next cycle.
- MAX_TERMS = 1: every accept closes a frame.

Optional Feature:
- Macro: MAC_ACC_SAT_EN.
- Defined: on any add with carry-out = 1, the accumulator saturates to all-ones (16'hFFFF) instead of wrapping. Later adds keep it at all-ones. out_ovf behaves identically.
- Undefined: modulo wrap as above; no saturation logic is built.

Test Plan:
- Frame of 3 terms: rst for 2 cycles, then products 16'h0010, 16'h0020, 16'h0030 (last on third) -> next cycle out_valid = 1, out_acc = 16'h0060, out_count = 3, out_ovf = 0; in_ready = 0 until out_ready.
- Overflow: products 16'hFFF0 then 16'h0020 with last -> wrap build gives out_acc = 16'h0010, out_ovf = 1; MAC_ACC_SAT_EN build gives out_acc = 16'hFFFF, out_ovf = 1.
- Forced close: 16 consecutive products of 16'h0001, in_last = 0 -> out_count = 16, out_acc = 16'h0010. The next frame starts from 0.
- Back-pressure: hold out_ready = 0 for 5 cycles after close while in_valid = 1 -> outputs stable, no accept. out_ready = 1 -> out_valid drops next cycle, in_ready rises.
- Abort: 2 terms (5, 7), then acc_clr together with in_valid/in_product = 9 -> 9 discarded. Then product 4 with last -> out_acc = 16'h0004, out_count = 1.
- Reset mid-HOLD: rst while out_valid = 1 -> next cycle all outputs 0, in_ready = 1.
